// File: rtl/rv_mem_pkg.sv
// Shared encodings for the RV32I memory stage: funct3 access codes, FSM states,
// write-back result-source codes and the registered execute->memory bundle.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2
    } res_src_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } acc_size_e;

    typedef struct packed {
        logic [31:0] alu_result;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  rd;
        logic [29:0] pc_p4;
        logic [1:0]  res_src;
        logic [2:0]  funct3;
        logic [31:0] rs2_val;
    } stage_t;

    // Unused funct3 codes (011/110/111) fall through to word accesses.
    function automatic acc_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            F3_W:        return SZ_W;
            default:     return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/rv_mem_if.sv
// Data-bus req/ack interface between the memory stage (master) and the data memory (slave).
interface rv_mem_if;

    logic        o_dbus_req;
    logic        o_dbus_we;
    logic [29:0] o_dbus_addr;
    logic [3:0]  o_dbus_be;
    logic [31:0] o_dbus_wdata;
    logic        i_dbus_ack;
    logic [31:0] i_dbus_rdata;

    modport master (
        output o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_be, o_dbus_wdata,
        input  i_dbus_ack, i_dbus_rdata
    );

    modport slave (
        input  o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_be, o_dbus_wdata,
        output i_dbus_ack, i_dbus_rdata
    );

endinterface

// File: rtl/rv_mem_align.sv
// Combinational lane logic: store byte enables / replicated data, load extraction
// with sign or zero extension, and the misalignment check.
module rv_mem_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rs2,
    input  logic [31:0] i_rdata,
    output logic        o_misaligned,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_wdata,
    output logic [31:0] o_load_val
);

    acc_size_e   w_size;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_size = f3_size(i_funct3);

    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_misaligned = 1'b0;
        o_st_be      = 4'b1111;
        o_st_wdata   = i_rs2;
        o_load_val   = i_rdata;
        case (w_size)
            SZ_B: begin
                o_st_be    = 4'b0001 << i_off;
                o_st_wdata = {4{i_rs2[7:0]}};
                o_load_val = {{24{(i_funct3 == F3_B) & w_byte[7]}}, w_byte};
            end
            SZ_H: begin
                o_misaligned = i_off[0];
                o_st_be      = 4'b0011 << {i_off[1], 1'b0};
                o_st_wdata   = {2{i_rs2[15:0]}};
                o_load_val   = {{16{(i_funct3 == F3_H) & w_half[15]}}, w_half};
            end
            default: o_misaligned = |i_off;
        endcase
    end

endmodule

// File: rtl/rv_mem_stage.sv
// RV32I memory stage: EX/MEM stage register plus the IDLE/BUS/DONE data-bus FSM
// that stalls the pipeline while a load or store is outstanding.
module rv_mem_stage
    import rv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned TMO_W          = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_flush,
    input  logic        i_stall,
    input  logic [31:0] i_alu_result,
    input  logic        i_reg_write,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [4:0]  i_rd,
    input  logic [29:0] i_pc_p4,
    input  logic [1:0]  i_res_src,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rs2_val,
    rv_mem_if.master    dbus,
    output logic        o_stall_req,
    output logic        o_misalign,
    output logic        o_bus_err,
    output logic [31:0] o_fwd_val,
    output logic [4:0]  o_rd,
    output logic        o_reg_write,
    output logic [1:0]  o_res_src,
    output logic [31:0] o_alu_result,
    output logic [31:0] o_load_val,
    output logic [29:0] o_pc_p4
);

    stage_t      r_stg;
    mem_state_e  r_state;
    logic [TMO_W-1:0] r_cnt;
    logic        r_bus_we;
    logic [29:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;
    logic [2:0]  r_bus_f3;
    logic [1:0]  r_bus_off;
    logic [31:0] r_load_val;
    logic        r_bus_err, r_kill, r_mis_done;

    stage_t      w_stg_in;
    logic        w_memop, w_misal_raw, w_misalign, w_launch, w_in_bus, w_req, w_adv, w_tmo;
    logic [TMO_W-1:0] w_cnt_nxt;
    logic [2:0]  w_f3;
    logic [1:0]  w_off;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata, w_load_ext;
    logic        w_bus_we;
    logic [29:0] w_bus_addr;
    logic [3:0]  w_bus_be;
    logic [31:0] w_bus_wdata;

    assign w_stg_in = '{alu_result: i_alu_result, reg_write: i_reg_write,
                        mem_read: i_mem_read, mem_write: i_mem_write, rd: i_rd,
                        pc_p4: i_pc_p4, res_src: i_res_src, funct3: i_funct3,
                        rs2_val: i_rs2_val};

    // A flush may clear the stage mid-transfer, so the bus side works from copies latched at launch.
    assign w_in_bus   = (r_state == ST_BUS);
    assign w_f3       = w_in_bus ? r_bus_f3  : r_stg.funct3;
    assign w_off      = w_in_bus ? r_bus_off : r_stg.alu_result[1:0];
    assign w_memop    = r_stg.mem_read | r_stg.mem_write;
    assign w_misalign = (r_state == ST_IDLE) & w_memop & w_misal_raw;
    assign w_launch   = (r_state == ST_IDLE) & w_memop & ~w_misal_raw;
    assign w_req      = w_launch | w_in_bus;
    assign w_adv      = i_flush | ~(i_stall | w_req);
    assign w_cnt_nxt  = w_in_bus ? r_cnt + TMO_W'(1) : TMO_W'(1);
    assign w_tmo      = (TIMEOUT_CYCLES != 0) && (w_cnt_nxt == TMO_W'(TIMEOUT_CYCLES));

    rv_mem_align u_align (
        .i_funct3     (w_f3),
        .i_off        (w_off),
        .i_rs2        (r_stg.rs2_val),
        .i_rdata      (dbus.i_dbus_rdata),
        .o_misaligned (w_misal_raw),
        .o_st_be      (w_st_be),
        .o_st_wdata   (w_st_wdata),
        .o_load_val   (w_load_ext)
    );

    always_comb begin
        w_bus_we    = 1'b0;
        w_bus_addr  = '0;
        w_bus_be    = '0;
        w_bus_wdata = '0;
        if (w_in_bus) begin
            w_bus_we    = r_bus_we;
            w_bus_addr  = r_bus_addr;
            w_bus_be    = r_bus_be;
            w_bus_wdata = r_bus_wdata;
        end else if (w_launch) begin
            w_bus_we    = r_stg.mem_write;
            w_bus_addr  = r_stg.alu_result[31:2];
            w_bus_be    = r_stg.mem_write ? w_st_be : 4'b1111;
            w_bus_wdata = r_stg.mem_write ? w_st_wdata : '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stg       <= '0;
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
            r_bus_f3    <= '0;
            r_bus_off   <= '0;
            r_load_val  <= '0;
            r_bus_err   <= 1'b0;
            r_kill      <= 1'b0;
            r_mis_done  <= 1'b0;
        end else begin
            if (i_flush)
                r_stg <= '0;
            else if (!(i_stall || w_req))
                r_stg <= w_stg_in;
            r_bus_err  <= 1'b0;
            r_mis_done <= w_adv ? 1'b0 : (r_mis_done | w_misalign);
            if (w_launch) begin
                r_bus_we    <= w_bus_we;
                r_bus_addr  <= w_bus_addr;
                r_bus_be    <= w_bus_be;
                r_bus_wdata <= w_bus_wdata;
                r_bus_f3    <= r_stg.funct3;
                r_bus_off   <= r_stg.alu_result[1:0];
            end
            case (r_state)
                ST_IDLE, ST_BUS: begin
                    if (w_req) begin
                        if (dbus.i_dbus_ack) begin
                            if (!w_bus_we)
                                r_load_val <= w_load_ext;
                            r_state <= ST_DONE;
                        end else if (w_tmo) begin
                            r_bus_err <= 1'b1;
                            r_kill    <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            r_cnt   <= w_cnt_nxt;
                            r_state <= ST_BUS;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_adv) begin
                        r_state <= ST_IDLE;
                        r_kill  <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dbus.o_dbus_req   = w_req & ~i_reset;
    assign dbus.o_dbus_we    = w_bus_we;
    assign dbus.o_dbus_addr  = w_bus_addr;
    assign dbus.o_dbus_be    = w_bus_be;
    assign dbus.o_dbus_wdata = w_bus_wdata;

    assign o_stall_req  = w_req;
    assign o_misalign   = w_misalign & ~r_mis_done;
    assign o_bus_err    = r_bus_err;
    assign o_fwd_val    = r_stg.alu_result;
    assign o_rd         = r_stg.rd;
    assign o_reg_write  = r_stg.reg_write & ~r_kill & ~w_misalign;
    assign o_res_src    = r_stg.res_src;
    assign o_alu_result = r_stg.alu_result;
    assign o_load_val   = r_load_val;
    assign o_pc_p4      = r_stg.pc_p4;

endmodule

// File: tb/tb_rv_mem_stage.sv
// Directed bench for rv_mem_stage: stores, loads with wait states, misalignment,
// timeout, flush mid-transfer, ALU pass-through and reset mid-transfer.
module tb_rv_mem_stage;

    logic        clk = 1'b0;
    logic        reset, flush, stall;
    logic [31:0] alu_result, rs2_val;
    logic        reg_write, mem_read, mem_write;
    logic [4:0]  rd;
    logic [29:0] pc_p4;
    logic [1:0]  res_src;
    logic [2:0]  funct3;
    logic        stall_req, misalign, bus_err, o_reg_write;
    logic [31:0] fwd_val, o_alu_result, load_val;
    logic [4:0]  o_rd;
    logic [1:0]  o_res_src;
    logic [29:0] o_pc_p4;

    int n_checks = 0;
    int n_errors = 0;

    rv_mem_if bus ();

    rv_mem_stage #(.TIMEOUT_CYCLES(4), .TMO_W(8)) dut (
        .i_clk(clk), .i_reset(reset), .i_flush(flush), .i_stall(stall),
        .i_alu_result(alu_result), .i_reg_write(reg_write), .i_mem_read(mem_read),
        .i_mem_write(mem_write), .i_rd(rd), .i_pc_p4(pc_p4), .i_res_src(res_src),
        .i_funct3(funct3), .i_rs2_val(rs2_val), .dbus(bus),
        .o_stall_req(stall_req), .o_misalign(misalign), .o_bus_err(bus_err),
        .o_fwd_val(fwd_val), .o_rd(o_rd), .o_reg_write(o_reg_write),
        .o_res_src(o_res_src), .o_alu_result(o_alu_result), .o_load_val(load_val),
        .o_pc_p4(o_pc_p4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic rw, input logic mr, input logic mw,
                         input logic [4:0] d, input logic [2:0] f3, input logic [31:0] s,
                         input logic [1:0] rs, input logic [29:0] pc);
        alu_result = a; reg_write = rw; mem_read = mr; mem_write = mw;
        rd = d; funct3 = f3; rs2_val = s; res_src = rs; pc_p4 = pc;
    endtask

    task automatic clear_in();
        drive(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'h0, 2'd0, 30'h0);
    endtask

    task automatic do_store(input string tag, input logic [31:0] a, input logic [2:0] f3,
                            input logic [31:0] s, input logic [29:0] w_addr,
                            input logic [3:0] w_be, input logic [31:0] w_data);
        drive(a, 1'b0, 1'b0, 1'b1, 5'd0, f3, s, 2'd0, 30'h10);
        cyc();
        clear_in();
        bus.i_dbus_ack = 1'b1;
        #1;
        chk({tag, " req"}, 32'(bus.o_dbus_req), 32'd1);
        chk({tag, " we"}, 32'(bus.o_dbus_we), 32'd1);
        chk({tag, " addr"}, 32'(bus.o_dbus_addr), 32'(w_addr));
        chk({tag, " be"}, 32'(bus.o_dbus_be), 32'(w_be));
        chk({tag, " wdata"}, bus.o_dbus_wdata, w_data);
        chk({tag, " stall"}, 32'(stall_req), 32'd1);
        cyc();
        bus.i_dbus_ack = 1'b0;
        #1;
        chk({tag, " done req"}, 32'(bus.o_dbus_req), 32'd0);
        chk({tag, " done stall"}, 32'(stall_req), 32'd0);
        cyc();
    endtask

    task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] rdata, input int unsigned waits,
                           input logic [29:0] w_addr, input logic [31:0] want, input bit hold);
        int unsigned stalls = 0;
        drive(a, 1'b1, 1'b1, 1'b0, 5'd5, f3, 32'h0, 2'd1, 30'h20);
        cyc();
        clear_in();
        for (int unsigned i = 0; i <= waits; i++) begin
            bus.i_dbus_ack   = (i == waits);
            bus.i_dbus_rdata = (i == waits) ? rdata : 32'h5A5A5A5A;
            #1;
            if (i == 0) begin
                chk({tag, " addr"}, 32'(bus.o_dbus_addr), 32'(w_addr));
                chk({tag, " be"}, 32'(bus.o_dbus_be), 32'hF);
                chk({tag, " we"}, 32'(bus.o_dbus_we), 32'd0);
            end
            if (stall_req) stalls++;
            cyc();
        end
        bus.i_dbus_ack = 1'b0;
        #1;
        chk({tag, " stall cycles"}, stalls, waits + 1);
        chk({tag, " load"}, load_val, want);
        chk({tag, " done stall"}, 32'(stall_req), 32'd0);
        chk({tag, " reg_write"}, 32'(o_reg_write), 32'd1);
        if (hold) begin
            stall = 1'b1;
            cyc();
            chk({tag, " held load"}, load_val, want);
            chk({tag, " held rd"}, 32'(o_rd), 32'd5);
            chk({tag, " held req"}, 32'(bus.o_dbus_req), 32'd0);
            stall = 1'b0;
        end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned nreq;
        reset = 1'b1; flush = 1'b0; stall = 1'b0;
        bus.i_dbus_ack = 1'b0; bus.i_dbus_rdata = 32'h0;
        clear_in();
        cyc(); cyc();
        reset = 1'b0;
        #1;
        chk("rst req", 32'(bus.o_dbus_req), 32'd0);
        chk("rst stall", 32'(stall_req), 32'd0);
        chk("rst fwd", fwd_val, 32'h0);
        chk("rst load", load_val, 32'h0);
        chk("rst be", 32'(bus.o_dbus_be), 32'h0);

        do_store("SW", 32'h100, 3'b010, 32'hDEADBEEF, 30'h40, 4'b1111, 32'hDEADBEEF);
        do_store("SH", 32'h6, 3'b001, 32'h1234ABCD, 30'h1, 4'b1100, 32'hABCDABCD);
        do_store("SB1", 32'h101, 3'b000, 32'h1234ABCD, 30'h40, 4'b0010, 32'hCDCDCDCD);
        do_store("SB3", 32'h103, 3'b000, 32'h00000055, 30'h40, 4'b1000, 32'h55555555);

        do_load("LB", 32'h203, 3'b000, 32'h80FFFF7F, 3, 30'h80, 32'hFFFFFF80, 1'b1);
        do_load("LBU", 32'h203, 3'b100, 32'h80FFFF7F, 3, 30'h80, 32'h00000080, 1'b0);
        do_load("LB0", 32'h200, 3'b000, 32'h80FFFF7F, 0, 30'h80, 32'h0000007F, 1'b0);
        do_load("LH", 32'h202, 3'b001, 32'h80FFFF7F, 0, 30'h80, 32'hFFFF80FF, 1'b0);
        do_load("LHU", 32'h202, 3'b101, 32'h80FFFF7F, 1, 30'h80, 32'h000080FF, 1'b0);
        do_load("LW", 32'h200, 3'b010, 32'h80FFFF7F, 0, 30'h80, 32'h80FFFF7F, 1'b0);
        do_load("LW011", 32'h204, 3'b011, 32'h13579BDF, 2, 30'h81, 32'h13579BDF, 1'b0);

        // misaligned halfword load
        drive(32'h5, 1'b1, 1'b1, 1'b0, 5'd9, 3'b001, 32'h0, 2'd1, 30'h0);
        cyc();
        clear_in();
        #1;
        chk("LHmis pulse", 32'(misalign), 32'd1);
        chk("LHmis req", 32'(bus.o_dbus_req), 32'd0);
        chk("LHmis stall", 32'(stall_req), 32'd0);
        chk("LHmis reg_write", 32'(o_reg_write), 32'd0);
        cyc();
        chk("LHmis after", 32'(misalign), 32'd0);

        // misaligned word load held by a downstream stall: still a single pulse
        drive(32'h102, 1'b1, 1'b1, 1'b0, 5'd9, 3'b010, 32'h0, 2'd1, 30'h0);
        cyc();
        clear_in();
        stall = 1'b1;
        #1;
        chk("LWmis pulse", 32'(misalign), 32'd1);
        cyc();
        chk("LWmis held pulse", 32'(misalign), 32'd0);
        chk("LWmis held rw", 32'(o_reg_write), 32'd0);
        chk("LWmis held rd", 32'(o_rd), 32'd9);
        stall = 1'b0;
        cyc();

        // timeout: no ack ever
        drive(32'h300, 1'b1, 1'b1, 1'b0, 5'd4, 3'b010, 32'h0, 2'd1, 30'h0);
        cyc();
        clear_in();
        nreq = 0;
        for (int i = 0; i < 10 && bus.o_dbus_req; i++) begin
            nreq++;
            cyc();
        end
        chk("TMO req cycles", nreq, 32'd4);
        chk("TMO bus_err", 32'(bus_err), 32'd1);
        chk("TMO reg_write", 32'(o_reg_write), 32'd0);
        chk("TMO stall", 32'(stall_req), 32'd0);
        cyc();
        chk("TMO err pulse", 32'(bus_err), 32'd0);

        // flush while the load is on the bus
        drive(32'h400, 1'b1, 1'b1, 1'b0, 5'd7, 3'b010, 32'h0, 2'd1, 30'h0);
        cyc();
        clear_in();
        cyc();
        flush = 1'b1;
        #1;
        chk("FL req at flush", 32'(bus.o_dbus_req), 32'd1);
        cyc();
        flush = 1'b0;
        #1;
        chk("FL req held", 32'(bus.o_dbus_req), 32'd1);
        chk("FL addr held", 32'(bus.o_dbus_addr), 32'h100);
        chk("FL reg_write", 32'(o_reg_write), 32'd0);
        chk("FL rd", 32'(o_rd), 32'd0);
        cyc();
        bus.i_dbus_ack = 1'b1; bus.i_dbus_rdata = 32'h11223344;
        #1;
        chk("FL req at ack", 32'(bus.o_dbus_req), 32'd1);
        cyc();
        bus.i_dbus_ack = 1'b0;
        #1;
        chk("FL done req", 32'(bus.o_dbus_req), 32'd0);
        chk("FL done stall", 32'(stall_req), 32'd0);
        chk("FL done reg_write", 32'(o_reg_write), 32'd0);
        cyc();

        // plain ALU op
        drive(32'h55, 1'b1, 1'b0, 1'b0, 5'd3, 3'b000, 32'h0, 2'd0, 30'h1234567);
        #1;
        chk("ADD fwd before", fwd_val, 32'h0);
        cyc();
        clear_in();
        #1;
        chk("ADD stall", 32'(stall_req), 32'd0);
        chk("ADD fwd", fwd_val, 32'h55);
        chk("ADD alu", o_alu_result, 32'h55);
        chk("ADD rd", 32'(o_rd), 32'd3);
        chk("ADD reg_write", 32'(o_reg_write), 32'd1);
        chk("ADD pc", 32'(o_pc_p4), 32'h1234567);
        cyc();
        chk("ADD after stall", 32'(stall_req), 32'd0);

        // reset mid-transfer
        drive(32'h500, 1'b1, 1'b1, 1'b0, 5'd6, 3'b010, 32'h0, 2'd1, 30'h3);
        cyc();
        clear_in();
        cyc();
        reset = 1'b1;
        #1;
        chk("RST req drop", 32'(bus.o_dbus_req), 32'd0);
        cyc();
        reset = 1'b0;
        #1;
        chk("RST stall", 32'(stall_req), 32'd0);
        chk("RST rd", 32'(o_rd), 32'd0);
        chk("RST reg_write", 32'(o_reg_write), 32'd0);
        chk("RST load", load_val, 32'h0);
        chk("RST pc", 32'(o_pc_p4), 32'h0);
        chk("RST res_src", 32'(o_res_src), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rv_mem_stage.md
Name: rv_mem_stage

Overview:
Memory stage of the 5-stage RV32I pipeline, directly downstream of the execute stage. Registers the execute-stage outputs and runs the load/store transaction on the data bus with a req/ack handshake. Aligns and sign- or zero-extends load data, generates byte enables for stores, and asserts a stall toward the hazard unit while a transfer is outstanding. Forwards its ALU result to the execute bypass network and its stage outputs to write-back.

Parameters:
TIMEOUT_CYCLES, 0, cycles to wait for i_dbus_ack before aborting; 0 disables the timeout
TMO_W, 8, width of the wait counter; TIMEOUT_CYCLES < 2**TMO_W

Ports:
i_clk  in  1  clock, all logic on posedge
i_reset  in  1  synchronous, active-high reset
i_flush  in  1  bubble the stage register
i_stall  in  1  hold the stage register (downstream stall)
i_alu_result  in  32  effective address or ALU result
i_reg_write  in  1  from execute
i_mem_read  in  1  from execute
i_mem_write  in  1  from execute
i_rd  in  5  from execute
i_pc_p4  in  30  PC+4 [31:2]
i_res_src  in  2  from execute
i_funct3  in  3  from execute
i_rs2_val  in  32  store data (already bypassed)
o_dbus_req  out  1  bus request
o_dbus_we  out  1  1=write
o_dbus_addr  out  30  word address [31:2]
o_dbus_be  out  4  byte enables
o_dbus_wdata  out  32  lane-replicated store data
i_dbus_ack  in  1  transfer complete; rdata valid on a read
i_dbus_rdata  in  32  read word
o_stall_req  out  1  freeze pipeline upstream of write-back
o_misalign  out  1  1-cycle pulse, misaligned access dropped
o_bus_err  out  1  1-cycle pulse, timeout abort
o_fwd_val  out  32  = registered ALU result (execute i_memory_rd_val)
o_rd  out  5  to write-back and hazard unit
o_reg_write  out  1  to write-back
o_res_src  out  2  to write-back
o_alu_result  out  32  to write-back
o_load_val  out  32  extended load data, valid in DONE
o_pc_p4  out  30  to write-back

Behaviour:
- Stage register: priority reset > flush (all fields 0) > hold while (i_stall | o_stall_req) > load.
- Reset: every output 0; FSM in IDLE; wait counter 0; the load-data register holds 0.
- FSM states: IDLE, BUS, DONE.
- IDLE with a registered mem_read/mem_write and an aligned address:
  - drive o_dbus_req=1 and o_stall_req=1 combinationally in the same cycle;
  - go to BUS, or straight to DONE if i_dbus_ack is already high.
- BUS:
  - hold req, we, addr, be and wdata stable until ack;
  - o_stall_req=1;
  - on ack, capture i_dbus_rdata and go to DONE.
- DONE:
  - req=0, o_stall_req=0, o_load_val valid;
  - next cycle IDLE, when the stage register advances.
- Minimum latency: 2 cycles (request cycle, then DONE).
- ALU, jump and nop instructions never stall.
- Alignment: misaligned is half with addr[0]=1, or word with addr[1:0]!=0.
  - No bus request.
  - o_misalign pulses for 1 cycle.
  - o_reg_write is forced to 0 for that instruction.
- Store byte enables and data:
  - SB: be = 0001<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = 0011<<{addr[1],1'b0}, wdata = {2{rs2[15:0]}}.
  - SW: be = 1111, wdata = rs2.
- Reads: o_dbus_be = 1111.
- Load extraction: LB/LBU use the byte at addr[1:0]; LH/LHU use the half at addr[1]; LW uses the full word. LB/LH sign-extend; LBU/LHU zero-extend. funct3 011/110/111 are treated as LW.
- Timeout (TIMEOUT_CYCLES>0):
  - counter increments each BUS cycle without ack;
  - at TIMEOUT_CYCLES, drop req, pulse o_bus_err, force reg_write to 0, go to DONE.
- Flush while in BUS: the transaction is not aborted. The FSM completes the handshake; the result is discarded and reg_write is cleared.
- Reset while in BUS drops req immediately; the bus slave tolerates this.
- Simultaneous i_stall during DONE: the load-data register holds until the stage advances.

Decomposition:
- Package rv_mem_pkg holds:
  - funct3 load/store encodings (F3_B/H/W/BU/HU);
  - a 2-bit enum for the FSM states;
  - res_src encodings shared with write-back.
- Sub-module rv_mem_align: combinational store byte-enable/lane generation plus load extraction/extension. The FSM stays in the parent.

Test Plan:
- SW addr 0x100, rs2=0xDEADBEEF, ack in the same cycle -> req 1 cycle, be=1111, addr=0x40, stall 1 cycle, DONE next cycle.
- LB addr 0x203, rdata=0x80FF_FF7F, ack after 3 wait cycles -> stall 4 cycles, o_load_val=0xFFFFFF80; the LBU variant gives 0x00000080.
- SH addr 0x6, rs2=0x1234ABCD -> be=1100, wdata=0xABCDABCD; LH addr 0x5 -> o_misalign pulse, no req, o_reg_write=0.
- TIMEOUT_CYCLES=4, LW with no ack -> req for 4 cycles, o_bus_err pulse, o_reg_write=0, stall released.
- LW in BUS, i_flush asserted, ack 2 cycles later -> req held until ack, result discarded, o_reg_write=0.
- ADD result 0x55, no mem op -> o_stall_req never 1, o_fwd_val=0x55 one cycle after capture; i_reset mid-BUS -> all outputs 0 next cycle.
